// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci sequencer: FSM state encoding,
// the seed value of the sequence and the default datapath widths.
package fib_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        W0   = 3'd1,
        W1   = 3'd2,
        RD   = 3'd3,
        ADD  = 3'd4,
        FIN  = 3'd5
    } fib_state_t;

    // fib(0) and fib(1) both take this value
    localparam int FIB_BASE_VAL = 1;

    // Default value/RAM data width and RAM address width
    localparam int FIB_DATA_W = 16;
    localparam int FIB_ADDR_W = 13;

endpackage

// File: rtl/fib_adder.sv
// Fibonacci term adder: produces the next term and its carry-out.
// Build option FIB_SATURATE_EN: once an add carries out (or a previous add
// of the same job did), the sum is clamped to all-ones; otherwise sums wrap.
module fib_adder
    import fib_pkg::*;
#(
    parameter int DATA_W = FIB_DATA_W
)(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_sat_hold,
    output logic [DATA_W-1:0] o_sum,
    output logic              o_carry
);

    logic [DATA_W-1:0] w_raw;

`ifndef FIB_SATURATE_EN
    // The hold input only matters when saturating
    logic w_unused_hold;
    assign w_unused_hold = i_sat_hold;
`endif

    // Full-width add with carry, then optional clamp
    always_comb begin
        {o_carry, w_raw} = {1'b0, i_a} + {1'b0, i_b};
`ifdef FIB_SATURATE_EN
        o_sum = (o_carry || i_sat_hold) ? {DATA_W{1'b1}} : w_raw;
`else
        o_sum = w_raw;
`endif
    end

endmodule

// File: rtl/fibonacci_sequencer.sv
// Fibonacci sequencer: writes fib(0..N) into an external dual-port RAM
// (port A write, port B read with one cycle of latency) and reports fib(N).
// Each new term is the previous term (kept in a register) plus the term two
// back, read from the RAM. Build option FIB_SATURATE_EN selects saturating
// sums in fib_adder; the default build wraps modulo 2^DATA_W.
module fibonacci_sequencer
    import fib_pkg::*;
#(
    parameter int DATA_W    = FIB_DATA_W,
    parameter int ADDR_W    = FIB_ADDR_W,
    parameter int BASE_ADDR = 0
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] n_in,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              overflow,
    output logic              err,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic [DATA_W-1:0] ram_data_a,
    output logic [ADDR_W-1:0] ram_addr_b,
    input  logic [DATA_W-1:0] ram_q_b
);

    localparam logic [DATA_W-1:0] ONE    = DATA_W'(FIB_BASE_VAL);
    localparam logic [DATA_W-1:0] TWO    = DATA_W'(2);
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
    // Largest N whose last term still lands inside the RAM
    localparam logic [63:0]       MAX_N  = (64'd1 << ADDR_W) - 64'd1 - 64'(BASE_ADDR);

    fib_state_t        r_state;
    logic [DATA_W-1:0] r_n;
    logic [DATA_W-1:0] r_prev;
    logic [DATA_W-1:0] r_i;
    logic [DATA_W-1:0] r_result;
    logic              r_done;
    logic              r_overflow;
    logic              r_err;

    logic [DATA_W-1:0] w_sum;
    logic              w_carry;
    logic              w_n_oor;

    assign w_n_oor = (64'(n_in) > MAX_N);

    // New term = term two back (from RAM) + previous term
    fib_adder #(
        .DATA_W (DATA_W)
    ) u_adder (
        .i_a        (ram_q_b),
        .i_b        (r_prev),
        .i_sat_hold (r_overflow),
        .o_sum      (w_sum),
        .o_carry    (w_carry)
    );

    assign done     = r_done;
    assign result   = r_result;
    assign overflow = r_overflow;
    assign err      = r_err;

    // RAM port and busy decode; the ADD write data depends on same-cycle read data
    always_comb begin
        busy       = (r_state != IDLE);
        ram_wren   = 1'b0;
        ram_addr_a = '0;
        ram_data_a = '0;
        ram_addr_b = '0;
        case (r_state)
            W0: begin
                ram_wren   = 1'b1;
                ram_addr_a = BASE_A;
                ram_data_a = ONE;
            end
            W1: begin
                ram_wren   = 1'b1;
                ram_addr_a = BASE_A + ADDR_W'(1);
                ram_data_a = ONE;
            end
            RD: begin
                ram_addr_b = BASE_A + ADDR_W'(r_i) - ADDR_W'(2);
            end
            ADD: begin
                ram_wren   = 1'b1;
                ram_addr_a = BASE_A + ADDR_W'(r_i);
                ram_data_a = w_sum;
            end
            default: ;
        endcase
    end

    // Sequencer FSM with registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_n        <= '0;
            r_prev     <= '0;
            r_i        <= '0;
            r_result   <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_n        <= n_in;
                        r_overflow <= 1'b0;
                        r_err      <= 1'b0;
                        r_prev     <= '0;
                        r_i        <= '0;
                        if (w_n_oor) begin
                            // Out-of-range target: report straight away, touch no RAM
                            r_err    <= 1'b1;
                            r_result <= '0;
                            r_done   <= 1'b1;
                            r_state  <= FIN;
                        end else begin
                            r_state <= W0;
                        end
                    end
                end
                W0: begin
                    r_state <= W1;
                end
                W1: begin
                    r_prev <= ONE;
                    r_i    <= TWO;
                    if (r_n <= ONE) begin
                        r_result <= ONE;
                        r_done   <= 1'b1;
                        r_state  <= FIN;
                    end else begin
                        r_state <= RD;
                    end
                end
                RD: begin
                    r_state <= ADD;
                end
                ADD: begin
                    r_prev     <= w_sum;
                    r_overflow <= r_overflow | w_carry;
                    if (r_i == r_n) begin
                        r_result <= w_sum;
                        r_done   <= 1'b1;
                        r_state  <= FIN;
                    end else begin
                        r_i     <= r_i + ONE;
                        r_state <= RD;
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fibonacci_sequencer.sv
// Bench for fibonacci_sequencer: table of jobs checked through a scoreboard
// queue, a behavioural dual-port RAM, plus hand-written sequences for the
// ignored start and the mid-job reset.
module tb_fibonacci_sequencer;

    localparam int DW = 16;
    localparam int AW = 13;

`ifdef FIB_SATURATE_EN
    localparam logic [DW-1:0] RES24 = 16'hFFFF;
`else
    localparam logic [DW-1:0] RES24 = 16'd9489;
`endif

    typedef struct {
        int            n;
        logic [DW-1:0] res;
        bit            chk_res;
        bit            ovf;
        bit            err;
        int            lat;
        int            writes;
    } vec_t;

    typedef struct {
        logic [DW-1:0] res;
        bit            chk_res;
        bit            ovf;
        bit            err;
        int            lat;
        int            writes;
        int            t0;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] n_in;
    logic          busy;
    logic          done;
    logic [DW-1:0] result;
    logic          overflow;
    logic          err;
    logic          ram_wren;
    logic [AW-1:0] ram_addr_a;
    logic [DW-1:0] ram_data_a;
    logic [AW-1:0] ram_addr_b;
    logic [DW-1:0] ram_q_b;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   wcount = 0;
    int   dones = 0;
    int   exp_dones = 0;
    exp_t sb[$];
    vec_t vecs[9];

    fibonacci_sequencer #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .BASE_ADDR (0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .n_in       (n_in),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .overflow   (overflow),
        .err        (err),
        .ram_wren   (ram_wren),
        .ram_addr_a (ram_addr_a),
        .ram_data_a (ram_data_a),
        .ram_addr_b (ram_addr_b),
        .ram_q_b    (ram_q_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter and dual-port RAM model (registered read on port B)
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_wren) mem[ram_addr_a] <= ram_data_a;
        ram_q_b <= mem[ram_addr_b];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Completion monitor: counts writes, pops the scoreboard on each done
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ram_wren) wcount++;
                if (done) begin
                    dones++;
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_done: got done=1 expected no pending job");
                    end else begin
                        e = sb.pop_front();
                        if (e.chk_res) chk("result", 64'(result), 64'(e.res));
                        chk("overflow", 64'(overflow), 64'(e.ovf));
                        chk("err", 64'(err), 64'(e.err));
                        chk("latency", 64'(cyc - e.t0), 64'(e.lat));
                        chk("writes", 64'(wcount), 64'(e.writes));
                    end
                    wcount = 0;
                end
            end
        end
    end

    task automatic push_job(input vec_t v);
        exp_t e;
        e.res     = v.res;
        e.chk_res = v.chk_res;
        e.ovf     = v.ovf;
        e.err     = v.err;
        e.lat     = v.lat;
        e.writes  = v.writes;
        e.t0      = cyc;
        sb.push_back(e);
        exp_dones++;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 300) begin
            @(posedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done in %0d cycles expected done", k);
            exp_dones -= sb.size();
            sb.delete();
        end
        #1;
    endtask

    task automatic run_job(input vec_t v);
        @(negedge clk);
        start = 1'b1;
        n_in  = DW'(v.n);
        push_job(v);
        @(negedge clk);
        start = 1'b0;
        wait_done();
        if (v.chk_res) chk("result_hold", 64'(result), 64'(v.res));
    endtask

    initial begin
        int t0;
        int fib_ref[11];
        fib_ref = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89};

        vecs[0] = '{0,    16'd1,     1'b1, 1'b0, 1'b0, 3,  2};
        vecs[1] = '{1,    16'd1,     1'b1, 1'b0, 1'b0, 3,  2};
        vecs[2] = '{2,    16'd2,     1'b1, 1'b0, 1'b0, 5,  3};
        vecs[3] = '{5,    16'd8,     1'b1, 1'b0, 1'b0, 11, 6};
        vecs[4] = '{10,   16'd89,    1'b1, 1'b0, 1'b0, 21, 11};
        vecs[5] = '{23,   16'd46368, 1'b1, 1'b0, 1'b0, 47, 24};
        vecs[6] = '{24,   RES24,     1'b1, 1'b1, 1'b0, 49, 25};
        vecs[7] = '{8192, 16'd0,     1'b0, 1'b0, 1'b1, 1,  0};
        vecs[8] = '{3,    16'd3,     1'b1, 1'b0, 1'b0, 7,  4};

        rst_n = 1'b0;
        start = 1'b0;
        n_in  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_wren", 64'(ram_wren), 64'd0);
        chk("rst_addr_a", 64'(ram_addr_a), 64'd0);
        chk("rst_addr_b", 64'(ram_addr_b), 64'd0);
        rst_n = 1'b1;

        // Back-to-back jobs from the table
        for (int i = 0; i < 8; i++) begin
            run_job(vecs[i]);
            if (i == 0) begin
                chk("n0_mem0", 64'(mem[0]), 64'd1);
                chk("n0_mem1", 64'(mem[1]), 64'd1);
            end
            if (i == 4) begin
                for (int a = 0; a < 11; a++) chk("n10_mem", 64'(mem[a]), 64'(fib_ref[a]));
            end
        end

        // Start pulsed in cycle 5 of an N=10 job is ignored
        @(negedge clk);
        start = 1'b1;
        n_in  = 16'd10;
        push_job(vecs[4]);
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20 && cyc != t0 + 5; k++) @(negedge clk);
        chk("busy_mid_job", 64'(busy), 64'd1);
        start = 1'b1;
        n_in  = 16'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (20) @(negedge clk);
        chk("result_after_ignored_start", 64'(result), 64'd89);
        chk("busy_after_ignored_start", 64'(busy), 64'd0);

        // Reset in cycle 7 of an N=10 job, then a clean N=3 job
        @(negedge clk);
        start = 1'b1;
        n_in  = 16'd10;
        t0    = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20 && cyc != t0 + 7; k++) @(negedge clk);
        chk("busy_before_reset", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_done", 64'(done), 64'd0);
        chk("mrst_result", 64'(result), 64'd0);
        chk("mrst_overflow", 64'(overflow), 64'd0);
        chk("mrst_err", 64'(err), 64'd0);
        chk("mrst_wren", 64'(ram_wren), 64'd0);
        chk("mrst_addr_a", 64'(ram_addr_a), 64'd0);
        chk("mrst_data_a", 64'(ram_data_a), 64'd0);
        chk("mrst_addr_b", 64'(ram_addr_b), 64'd0);
        wcount = 0;
        @(negedge clk);
        rst_n = 1'b1;
        run_job(vecs[8]);

        repeat (5) @(negedge clk);
        chk("done_count", 64'(dones), 64'(exp_dones));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fibonacci_sequencer.md
FIBONACCI_SEQUENCER -- requirements
Module: fibonacci_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning the value and RAM data width.
REQ-002 SHALL have parameter ADDR_W, default 13, meaning the RAM address width.
REQ-003 SHALL have parameter BASE_ADDR, default 0, meaning the RAM word address of fib(0).
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state changes occur on its rising edge.
REQ-005 SHALL have port rst_n  input  1  meaning the reset, which is asynchronous and active-low.
REQ-006 SHALL have port start  input  1  meaning the request to begin a computation.
REQ-007 SHALL have port n_in  input  DATA_W  meaning the target index N, sampled with start.
REQ-008 SHALL have port busy  output  1  meaning a computation is in progress.
REQ-009 SHALL have port done  output  1  meaning a one-cycle completion pulse.
REQ-010 SHALL have port result  output  DATA_W  meaning fib(N), valid from done until the next accepted start.
REQ-011 SHALL have port overflow  output  1  meaning sticky arithmetic overflow for the current job.
REQ-012 SHALL have port err  output  1  meaning N is out of the RAM range.
REQ-013 SHALL have port ram_wren  output  1  meaning the port-A write enable.
REQ-014 SHALL have port ram_addr_a  output  ADDR_W  meaning the port-A write address.
REQ-015 SHALL have port ram_data_a  output  DATA_W  meaning the port-A write data.
REQ-016 SHALL have port ram_addr_b  output  ADDR_W  meaning the port-B read address.
REQ-017 SHALL have port ram_q_b  input  DATA_W  meaning the port-B read data, returned 1 cycle after the address.

Function
REQ-018 SHALL define the sequence as fib(0)=fib(1)=1 and fib(i)=fib(i-1)+fib(i-2), writing fib(i) to address BASE_ADDR+i.
REQ-019 SHALL implement the states IDLE, W0, W1, RD, ADD and FIN.
REQ-020 SHALL, in IDLE with start=1, latch N, clear overflow and err, and go to W0; otherwise it SHALL stay in IDLE.
REQ-021 SHALL, in IDLE with start=1 and N > 2^ADDR_W-1-BASE_ADDR, set err, perform no writes, and go to FIN.
REQ-022 SHALL, in W0, write 1 to BASE_ADDR+0 and go to W1.
REQ-023 SHALL, in W1, write 1 to BASE_ADDR+1, set prev=1 and i=2, and go to FIN if N<=1, else to RD.
REQ-024 SHALL, in RD, drive ram_addr_b=BASE_ADDR+i-2 with ram_wren=0, and go to ADD.
REQ-025 SHALL, in ADD, form sum=ram_q_b+prev, write sum to BASE_ADDR+i, set prev=sum, and go to FIN if i==N, else increment i and go to RD.
REQ-026 SHALL, in FIN, drive result=prev (or 1 when N<=1), pulse done for exactly 1 cycle, and return to IDLE.
REQ-027 SHALL, with start sampled at edge 0, assert done in cycle 2N+1 for N>=2, in cycle 3 for N<=1, and in cycle 1 when err is set.
REQ-028 SHALL drive busy=1 in every state except IDLE.
REQ-029 SHALL ignore start while busy=1.
REQ-030 SHALL accept start in the cycle immediately after FIN.
REQ-031 SHALL set overflow when the DATA_W-bit add carries out, and hold it until the next accepted start.
REQ-032 SHALL drive ram_wren=1 only in W0, W1 and ADD.
REQ-033 SHALL drive ram_addr_a, ram_data_a and ram_addr_b to 0 when they are unused.

Reset
REQ-034 SHALL, on rst_n=0 at any time including mid-job, enter IDLE immediately and drive busy, done, overflow, err and ram_wren to 0.
REQ-035 SHALL, on reset, clear result, prev, i and all address outputs to 0.
REQ-036 SHALL treat any RAM contents written before a mid-job reset as undefined.

Configuration
REQ-037 SHALL, with FIB_SATURATE_EN defined, write and hold DATA_W'hFFFF…F when an add overflows, for that term and all later terms.
REQ-038 SHALL, without FIB_SATURATE_EN, wrap sums modulo 2^DATA_W; overflow reporting SHALL be identical in both builds.

Structure
REQ-039 SHALL place the state enum typedef, the base value 1, and the default widths in shared package fib_pkg.
REQ-040 SHALL contain one sub-module, fib_adder, which computes the sum, the carry flag, and the optional saturation.

Verification
REQ-041 SHALL cover: N=0 -> writes 1@0 and 1@1, result=1, done in cycle 3.
REQ-042 SHALL cover: N=10 -> result=89, RAM[0..10]=1,1,2,3,5,8,13,21,34,55,89, done in cycle 21, overflow=0.
REQ-043 SHALL cover: N=24 -> overflow=1 and result=9489 in the wrap build, or 65535 in the FIB_SATURATE_EN build.
REQ-044 SHALL cover: N=8192 with BASE_ADDR=0 -> err=1, no ram_wren, done in cycle 1.
REQ-045 SHALL cover: start pulsed in cycle 5 of an N=10 job -> ignored, single done, result=89.
REQ-046 SHALL cover: rst_n low in cycle 7 of an N=10 job -> IDLE with all outputs 0, after which N=3 -> result=3.
